rdp_systolic_xor_stage: RTL

- Parametrised, pipelined successor of the RDP systolic data cell.
- Combines NIN input lanes into two parity outputs (k1 = row group, k2 = diagonal group) under run-time lane masks.
- Has a valid/ready handshake, a registered output with skid buffer, and an optional multi-beat XOR-accumulate mode for stripe-wide parity.
- Sits between the stripe fetch path and the parity write-back in the RDP systolic array.

---
 rtl/rdp_pkg.sv | 20 ++
 rtl/rdp_skid_buf.sv | 68 ++++++
 rtl/rdp_systolic_xor_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rdp_pkg.sv
// Shared types and constants for the RDP systolic cells.
// Lane-width helper, classic-mapping default masks and the stripe FSM states.
package rdp_pkg;

  function automatic int rdp_lane_w(input int slices, input int data_width);
    return slices * data_width;
  endfunction

  localparam int RDP_NIN = 5;

  // Lane order is {c, k11, k10, k9, k8}: k1 = k8^k9^c, k2 = k10^k11^c
  localparam logic [RDP_NIN-1:0] RDP_K1_MASK = 5'b10011;
  localparam logic [RDP_NIN-1:0] RDP_K2_MASK = 5'b11100;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } rdp_state_e;

endpackage

// File: rtl/rdp_skid_buf.sv
// Registered output stage with a one-entry skid, carrying DW bits of payload.
// in_ready is a flop, so there is no combinational path from out_ready back upstream.
module rdp_skid_buf #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] in_dat,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_dat,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          out_v_q, out_v_d;
  logic          skid_v_q, skid_v_d;
  logic          rdy_q;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (skid_v_q) begin
      // Upstream is blocked while the skid is occupied, so only draining can happen
      if (out_ready) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_d   = '0;
        skid_v_d = 1'b0;
      end
    end else if (in_valid && rdy_q) begin
      if (!out_v_q || out_ready) begin
        out_d   = in_dat;
        out_v_d = 1'b1;
      end else begin
        skid_d   = in_dat;
        skid_v_d = 1'b1;
      end
    end else if (out_ready) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_dat   = out_q;
  assign out_valid = out_v_q;

endmodule

// File: rtl/rdp_systolic_xor_stage.sv
// Masked lane-XOR into row (k1) and diagonal (k2) parity, per beat or accumulated per stripe.
//   state | meaning
//   IDLE  | no open stripe; cfg_* sampled on the next accepted beat
//   ACCUM | stripe open; acc holds XOR of beats so far, masks latched
module rdp_systolic_xor_stage
  import rdp_pkg::*;
#(
  parameter int SLICES     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NIN        = 5,
  parameter int MAX_BEATS  = 16,
  localparam int W         = rdp_lane_w(SLICES, DATA_WIDTH),
  localparam int CW        = $clog2(MAX_BEATS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NIN*W-1:0] t_dat,
  input  logic             t_valid,
  input  logic             t_last,
  output logic             t_ready,
  input  logic [NIN-1:0]   cfg_k1_mask,
  input  logic [NIN-1:0]   cfg_k2_mask,
  input  logic             cfg_accum,
  output logic [W-1:0]     i_k1_dat,
  output logic [W-1:0]     i_k2_dat,
  output logic             i_valid,
  input  logic             i_ready,
  output logic             err_overrun
);

  rdp_state_e     state_q, state_d;
  logic [W-1:0]   acc1_q, acc1_d, acc2_q, acc2_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NIN-1:0] mask1_q, mask1_d, mask2_q, mask2_d;
  logic           err_q;

  logic [NIN-1:0] use_m1, use_m2;
  logic [W-1:0]   x1, x2;
  logic [W-1:0]   res1, res2;
  logic           accept;
  logic           emit;
  logic           ovr_set;

  assign accept = t_valid && t_ready;

  // Within a stripe the masks latched at its first beat apply
  always_comb begin
    use_m1 = (state_q == IDLE) ? cfg_k1_mask : mask1_q;
    use_m2 = (state_q == IDLE) ? cfg_k2_mask : mask2_q;
    x1 = '0;
    x2 = '0;
    for (int n = 0; n < NIN; n++) begin
      if (use_m1[n]) x1 = x1 ^ t_dat[n*W +: W];
      if (use_m2[n]) x2 = x2 ^ t_dat[n*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    cnt_d   = cnt_q;
    mask1_d = mask1_q;
    mask2_d = mask2_q;
    emit    = 1'b0;
    ovr_set = 1'b0;
    res1    = x1;
    res2    = x2;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!cfg_accum || t_last) begin
            emit = 1'b1;
          end else begin
            state_d = ACCUM;
            acc1_d  = x1;
            acc2_d  = x2;
            cnt_d   = CW'(1);
            mask1_d = cfg_k1_mask;
            mask2_d = cfg_k2_mask;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          // A stripe that reaches MAX_BEATS without t_last is force-closed
          if (t_last || cnt_q == CW'(MAX_BEATS - 1)) begin
            emit    = 1'b1;
            res1    = acc1_q ^ x1;
            res2    = acc2_q ^ x2;
            ovr_set = !t_last;
            state_d = IDLE;
            acc1_d  = '0;
            acc2_d  = '0;
            cnt_d   = '0;
          end else begin
            acc1_d = acc1_q ^ x1;
            acc2_d = acc2_q ^ x2;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc1_q  <= '0;
      acc2_q  <= '0;
      cnt_q   <= '0;
      mask1_q <= '0;
      mask2_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      cnt_q   <= cnt_d;
      mask1_q <= mask1_d;
      mask2_q <= mask2_d;
      if (ovr_set) err_q <= 1'b1;
    end
  end

  rdp_skid_buf #(
    .DW(2 * W)
  ) u_out (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_dat   ({res2, res1}),
    .in_valid (emit),
    .in_ready (t_ready),
    .out_dat  ({i_k2_dat, i_k1_dat}),
    .out_valid(i_valid),
    .out_ready(i_ready)
  );

  assign err_overrun = err_q;

endmodule
